// File: rtl/sd_xfer_sequencer.sv
// SD transfer sequencer: runs the init engine, then reads num_blocks blocks from base_addr,
// with per-operation timeout, bounded retry, abort and error reporting.
module sd_xfer_sequencer #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned NBLK_W      = 8,
    parameter int unsigned BLOCK_BYTES = 512,
    parameter int unsigned ADDR_MODE   = 0,
    parameter int unsigned TIMEOUT     = 1000000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              go,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [NBLK_W-1:0] num_blocks,
    output logic              init_start,
    input  logic              init_done,
    input  logic              init_err,
    output logic              read_start,
    output logic [ADDR_W-1:0] read_addr,
    input  logic              read_done,
    input  logic              read_err,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [NBLK_W-1:0] blocks_done,
    output logic [3:0]        state_dbg
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [RTY_W-1:0]  RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [ADDR_W-1:0] ADDR_INC = (ADDR_MODE != 0) ? ADDR_W'(1) : ADDR_W'(BLOCK_BYTES);

    typedef enum logic [3:0] {
        StIdle = 4'd0,
        StInit = 4'd1,
        StGap  = 4'd2,
        StRead = 4'd3,
        StNext = 4'd4,
        StDone = 4'd5,
        StFail = 4'd6
    } state_t;

    state_t            state_q, state_d;
    logic              go_q;
    logic              init_ok_q;
    logic [NBLK_W-1:0] nblk_q;
    logic [RTY_W-1:0]  retry_q;
    logic [TMO_W-1:0]  tmo_q;
    logic              go_edge, tmo_hit, retry_left, last_blk, accept;

    assign state_dbg = state_q;

    always_comb begin
        go_edge    = go & ~go_q;
        tmo_hit    = (tmo_q == TMO_LAST);
        retry_left = (retry_q < RTY_MAX);
        last_blk   = ((blocks_done + NBLK_W'(1)) == nblk_q);
        accept     = 1'b0;
        state_d    = state_q;
        unique case (state_q)
            StIdle, StDone, StFail: begin
                if (go_edge) begin
                    accept  = 1'b1;
                    state_d = StInit;
                end
            end
            // A completion in the same cycle as the timeout takes precedence over it.
            StInit: begin
                if (init_done && !init_err) state_d = StGap;
                else if (init_done || tmo_hit) state_d = retry_left ? StGap : StFail;
            end
            StGap: begin
                if (!init_ok_q)          state_d = StInit;
                else if (nblk_q == '0)   state_d = StDone;
                else                     state_d = StRead;
            end
            StRead: begin
                if (read_done && !read_err) state_d = StNext;
                else if (read_done || tmo_hit) state_d = retry_left ? StGap : StFail;
            end
            StNext:  state_d = last_blk ? StDone : StGap;
            default: state_d = StIdle;
        endcase
        if (abort) begin
            state_d = StIdle;
            accept  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= StIdle;
            go_q        <= 1'b0;
            init_ok_q   <= 1'b0;
            nblk_q      <= '0;
            retry_q     <= '0;
            tmo_q       <= '0;
            init_start  <= 1'b0;
            read_start  <= 1'b0;
            read_addr   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= 2'd0;
            blocks_done <= '0;
        end else begin
            go_q       <= go;
            state_q    <= state_d;
            init_start <= (state_d == StInit);
            read_start <= (state_d == StRead);
            busy       <= !(state_d inside {StIdle, StDone, StFail});
            done       <= (state_d == StDone);
            error      <= (state_d == StFail);

            // Count only while staying in an engine state; any transition restarts the budget.
            if ((state_d == state_q) && (state_q == StInit || state_q == StRead)) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end else begin
                tmo_q <= '0;
            end

            if (accept) begin
                read_addr   <= base_addr;
                nblk_q      <= num_blocks;
                blocks_done <= '0;
                err_code    <= 2'd0;
                retry_q     <= '0;
                init_ok_q   <= 1'b0;
            end

            if (!abort) begin
                case (state_q)
                    StInit: begin
                        if (init_done && !init_err) begin
                            retry_q   <= '0;
                            init_ok_q <= 1'b1;
                        end else if (init_done || tmo_hit) begin
                            if (retry_left) retry_q <= retry_q + RTY_W'(1);
                            else            err_code <= init_done ? 2'd1 : 2'd3;
                        end
                    end
                    StRead: begin
                        if (!(read_done && !read_err) && (read_done || tmo_hit)) begin
                            if (retry_left) retry_q <= retry_q + RTY_W'(1);
                            else            err_code <= read_done ? 2'd2 : 2'd3;
                        end
                    end
                    StNext: begin
                        blocks_done <= blocks_done + NBLK_W'(1);
                        read_addr   <= read_addr + ADDR_INC;
                        retry_q     <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
